// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared types and byte-enable decode for the RAM port arbiter
package ram_arb_pkg;
  typedef enum logic [1:0] {IDLE, GNT0, GNT1} arb_state_t;
  typedef logic master_id_t;
  localparam master_id_t M0 = 1'b0;
  localparam master_id_t M1 = 1'b1;
  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;
  typedef struct packed {
    logic       valid;
    master_id_t owner;
    logic       err;
  } rsp_tag_t;
  function automatic logic [3:0] byte_enable(input logic [1:0] size, input logic [1:0] addr_lo);
    return size >= SIZE_WORD ? 4'b1111 : (size == SIZE_BYTE ? 4'b0001 : 4'b0011) << addr_lo;
  endfunction
endpackage

// File: rtl/rsp_pipe.sv
// rsp_pipe: DEPTH-stage tag shift register aligning read tags with RAM read latency
module rsp_pipe
  import ram_arb_pkg::*;
#(
  parameter int DEPTH = 1
)(
  input  logic     clk,
  input  logic     reset,
  input  rsp_tag_t push,
  output rsp_tag_t tail
);
  rsp_tag_t stage [DEPTH];
  always_ff @(posedge clk or negedge reset)
    if (!reset) stage <= '{default: '0};
    else begin
      stage[0] <= push;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  assign tail = stage[DEPTH-1];
endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares the RAM data port between the CPU dBus (M0) and a loader master (M1)
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int WL = 32,
  parameter int RAM_DEPTH = 8192,
  parameter int RAM_LATENCY = 1,
  parameter int MAX_BURST = 8,
  localparam int AW = $clog2(RAM_DEPTH)
)(
  input  logic            clk,
  input  logic            reset,
  input  logic            m0_cmd_valid,
  output logic            m0_cmd_ready,
  input  logic            m0_cmd_wr,
  input  logic [WL-1:0]   m0_cmd_addr,
  input  logic [WL-1:0]   m0_cmd_data,
  input  logic [1:0]      m0_cmd_size,
  output logic            m0_rsp_valid,
  output logic            m0_rsp_error,
  output logic [WL-1:0]   m0_rsp_data,
  input  logic            m1_cmd_valid,
  output logic            m1_cmd_ready,
  input  logic            m1_cmd_wr,
  input  logic [WL-1:0]   m1_cmd_addr,
  input  logic [WL-1:0]   m1_cmd_data,
  input  logic [1:0]      m1_cmd_size,
  output logic            m1_rsp_valid,
  output logic            m1_rsp_error,
  output logic [WL-1:0]   m1_rsp_data,
  output logic [WL/8-1:0] ram_we,
  output logic [AW-1:0]   ram_addr,
  output logic [WL-1:0]   ram_din,
  input  logic [WL-1:0]   ram_dout
);
  localparam int NB = WL / 8;
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BURST);
  arb_state_t state, state_nxt;
  master_id_t prio, prio_nxt, own, gid;
  logic [CW-1:0] burst_cnt, cnt_nxt;
  logic any, keep, wr, in_range;
  logic [WL-1:0] addr;
  logic [1:0] size;
  rsp_tag_t push, tail;
  always_comb begin
    own = state == GNT1 ? M1 : M0;
    any = m0_cmd_valid | m1_cmd_valid;
    keep = state != IDLE && (own == M1 ? m1_cmd_valid : m0_cmd_valid) &&
           (burst_cnt < MAX_CNT || !(own == M1 ? m0_cmd_valid : m1_cmd_valid));
    gid = keep ? own : state != IDLE ? ~own : m0_cmd_valid && m1_cmd_valid ? prio : m1_cmd_valid;
    state_nxt = !any ? IDLE : gid == M1 ? GNT1 : GNT0;
    prio_nxt = !any && state != IDLE ? ~own : prio;
    cnt_nxt = !any ? '0 : !keep ? CW'(1) : burst_cnt == MAX_CNT ? burst_cnt : burst_cnt + 1'b1;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      prio <= M0;
      burst_cnt <= '0;
    end else begin
      state <= state_nxt;
      prio <= prio_nxt;
      burst_cnt <= cnt_nxt;
    end
  assign m0_cmd_ready = any && gid == M0;
  assign m1_cmd_ready = any && gid == M1;
  assign addr = gid == M1 ? m1_cmd_addr : m0_cmd_addr;
  assign wr = gid == M1 ? m1_cmd_wr : m0_cmd_wr;
  assign size = gid == M1 ? m1_cmd_size : m0_cmd_size;
  assign ram_din = gid == M1 ? m1_cmd_data : m0_cmd_data;
  assign in_range = addr[WL-1:AW+2] == '0;
  assign ram_addr = addr[AW+1:2];
  assign ram_we = any && wr && in_range ? NB'(byte_enable(size, addr[1:0])) : '0;
  assign push = '{any && !wr, gid, !in_range};
  rsp_pipe #(.DEPTH(RAM_LATENCY)) u_pipe (.clk, .reset, .push, .tail);
  assign m0_rsp_valid = tail.valid && tail.owner == M0;
  assign m1_rsp_valid = tail.valid && tail.owner == M1;
  assign m0_rsp_error = m0_rsp_valid && tail.err;
  assign m1_rsp_error = m1_rsp_valid && tail.err;
  assign m0_rsp_data = tail.err ? '0 : ram_dout;
  assign m1_rsp_data = tail.err ? '0 : ram_dout;
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed and random checks of ram_port_arbiter against a behavioural arbiter/RAM model
module tb_ram_port_arbiter;
  localparam int MAXB = 4;
  logic clk = 0, reset = 0, ram_init = 0;
  always #5 clk = ~clk;
  logic v[2], wr[2];
  logic [31:0] addr[2], data[2];
  logic [1:0] size[2];
  logic r0, r1, rv0, rv1, re0, re1;
  logic [31:0] rd0, rd1, ram_din, ram_dout;
  logic [3:0] ram_we;
  logic [12:0] ram_addr;
  logic [31:0] mem [8192];
  logic [31:0] ref_mem [8192];
  typedef struct {int due; int m; bit err; logic [31:0] data;} rsp_t;
  rsp_t q[$];
  int m_owner = -1, m_run = 0, m_prio = 0, cyc = 0, errors = 0, checks = 0;
  logic s_r0, s_r1, s_rv0, s_rv1, s_re0;
  logic [3:0] s_we;
  logic [12:0] s_addr;
  logic [31:0] s_rd0;
  logic [11:0] gs;

  ram_port_arbiter #(.WL(32), .RAM_DEPTH(8192), .RAM_LATENCY(1), .MAX_BURST(MAXB)) dut (
    .clk(clk), .reset(reset),
    .m0_cmd_valid(v[0]), .m0_cmd_ready(r0), .m0_cmd_wr(wr[0]), .m0_cmd_addr(addr[0]),
    .m0_cmd_data(data[0]), .m0_cmd_size(size[0]),
    .m0_rsp_valid(rv0), .m0_rsp_error(re0), .m0_rsp_data(rd0),
    .m1_cmd_valid(v[1]), .m1_cmd_ready(r1), .m1_cmd_wr(wr[1]), .m1_cmd_addr(addr[1]),
    .m1_cmd_data(data[1]), .m1_cmd_size(size[1]),
    .m1_rsp_valid(rv1), .m1_rsp_error(re1), .m1_rsp_data(rd1),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout));

  function automatic logic [31:0] init_val(int i);
    return i == 4 ? 32'hDEADBEEF : (32'(i) * 32'h9E3779B1) ^ 32'h13579BDF;
  endfunction

  always @(posedge clk) begin
    if (ram_init) for (int i = 0; i < 8192; i++) mem[i] <= init_val(i);
    else for (int b = 0; b < 4; b++) if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
    ram_dout <= mem[ram_addr];
  end

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set(int m, logic val, logic w_, logic [31:0] a_, logic [31:0] d_, logic [1:0] s_);
    v[m] = val; wr[m] = w_; addr[m] = a_; data[m] = d_; size[m] = s_;
  endtask

  task automatic idle();
    v[0] = 0; v[1] = 0;
  endtask

  task automatic cycle();
    int w;
    logic [31:0] a, d;
    logic [3:0] be, we;
    bit inr, e;
    @(negedge clk);
    w = -1;
    if (m_owner >= 0 && v[m_owner] && (m_run < MAXB || !v[1 - m_owner])) w = m_owner;
    else if (v[0] && v[1]) w = m_owner >= 0 ? 1 - m_owner : m_prio;
    else if (v[0]) w = 0;
    else if (v[1]) w = 1;
    a = w >= 0 ? addr[w] : 32'h0;
    d = w >= 0 ? data[w] : 32'h0;
    be = w < 0 ? 4'h0 : size[w] == 0 ? 4'(1 << a[1:0]) : size[w] == 1 ? 4'(3 << a[1:0]) : 4'hF;
    inr = a[31:15] == 0;
    we = (w >= 0 && wr[w] && inr) ? be : 4'h0;
    chk("ready0", r0, w == 0);
    chk("ready1", r1, w == 1);
    chk("both_ready", r0 & r1, 0);
    chk("ram_we", ram_we, we);
    if (w >= 0) chk("ram_addr", ram_addr, a[14:2]);
    if (we != 0) chk("ram_din", ram_din, d);
    for (int m = 0; m < 2; m++) begin
      e = q.size() > 0 && q[0].due == cyc && q[0].m == m;
      chk(m ? "rsp_valid1" : "rsp_valid0", m ? rv1 : rv0, e);
      if (e) begin
        chk(m ? "rsp_data1" : "rsp_data0", m ? rd1 : rd0, q[0].data);
        chk(m ? "rsp_error1" : "rsp_error0", m ? re1 : re0, q[0].err);
      end
    end
    if (q.size() > 0 && q[0].due == cyc) void'(q.pop_front());
    s_r0 = r0; s_r1 = r1; s_rv0 = rv0; s_rv1 = rv1; s_re0 = re0;
    s_we = ram_we; s_addr = ram_addr; s_rd0 = rd0;
    @(posedge clk);
    #1;
    cyc++;
    if (w >= 0) begin
      if (!wr[w]) q.push_back('{cyc, w, !inr, inr ? ref_mem[a[14:2]] : 32'h0});
      for (int b = 0; b < 4; b++) if (we[b]) ref_mem[a[14:2]][8*b +: 8] = d[8*b +: 8];
      m_run = w == m_owner ? (m_run < MAXB ? m_run + 1 : MAXB) : 1;
      m_owner = w;
    end else begin
      if (m_owner >= 0) m_prio = 1 - m_owner;
      m_owner = -1;
      m_run = 0;
    end
  endtask

  task automatic do_reset();
    reset = 0;
    #1;
    chk("rst_rsp_valid0", rv0, 0);
    chk("rst_rsp_valid1", rv1, 0);
    chk("rst_rsp_error0", re0, 0);
    idle();
    #1;
    chk("rst_ready0", r0, 0);
    chk("rst_ready1", r1, 0);
    chk("rst_we", ram_we, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1;
    @(posedge clk);
    #1;
    q.delete();
    m_owner = -1; m_run = 0; m_prio = 0;
  endtask

  initial begin
    for (int m = 0; m < 2; m++) set(m, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8192; i++) ref_mem[i] = init_val(i);
    ram_init = 1;
    @(posedge clk);
    #1;
    ram_init = 0;
    do_reset();
    // simultaneous requests from IDLE: M0 first, then M1 after a release
    set(0, 1, 0, 32'h20, 0, 2); set(1, 1, 0, 32'h24, 0, 2);
    cycle();
    chk("simul_first_m0", s_r0, 1);
    idle(); cycle();
    set(0, 1, 0, 32'h28, 0, 2); set(1, 1, 0, 32'h2C, 0, 2);
    cycle();
    chk("simul_second_m1", s_r1, 1);
    idle(); cycle(); cycle();
    // single read by M0
    set(0, 1, 0, 32'h10, 0, 2);
    cycle();
    chk("read_same_cycle_ready", s_r0, 1);
    idle(); cycle();
    chk("read_rsp_valid", s_rv0, 1);
    chk("read_deadbeef", s_rd0, 32'hDEADBEEF);
    chk("read_m1_quiet", s_rv1, 0);
    // byte write by M1, then word read back by M0
    set(1, 1, 1, 32'h7, 32'hAB00_0000, 0);
    cycle();
    chk("byte_we", s_we, 4'b1000);
    chk("byte_addr", s_addr, 1);
    idle(); set(0, 1, 0, 32'h4, 0, 2);
    cycle();
    idle(); cycle();
    chk("byte_readback", s_rd0[31:24], 8'hAB);
    // fairness from a known priority
    do_reset();
    for (int i = 0; i < 12; i++) begin
      set(0, 1, 0, {17'b0, 15'($urandom) & 15'h7FFC}, 0, 2);
      set(1, 1, 0, {17'b0, 15'($urandom) & 15'h7FFC}, 0, 2);
      cycle();
      gs[i] = s_r0;
    end
    chk("fairness", gs, 12'hF0F);
    idle(); cycle(); cycle();
    // out-of-range read and write
    set(0, 1, 0, 32'h0001_0000, 0, 2);
    cycle();
    idle(); cycle();
    chk("oor_err", s_re0, 1);
    chk("oor_data", s_rd0, 0);
    set(0, 1, 1, 32'h0001_0000, 32'h1234_5678, 2);
    cycle();
    chk("oor_we", s_we, 0);
    idle(); cycle();
    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      for (int m = 0; m < 2; m++)
        set(m, $urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 15) == 0 ? $urandom : {17'b0, 15'($urandom)},
            $urandom, 2'($urandom));
      cycle();
    end
    idle(); cycle(); cycle();
    // reset in the cycle after an accepted read
    set(0, 1, 0, 32'h30, 0, 2);
    cycle();
    do_reset();
    repeat (3) cycle();
    set(0, 1, 0, 32'h40, 0, 2); set(1, 1, 0, 32'h44, 0, 2);
    cycle();
    chk("post_reset_prio_m0", s_r0, 1);
    idle(); cycle(); cycle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
